mul_writeback_seq: RTL and testbench

//  Downstream stage of the RISC-SPM ALU. Latches ALU status flags into the processor status register.

---
 rtl/risc_spm_pkg.sv | 31 +++
 rtl/mul_writeback_seq_rise_detect.sv | 22 ++
 rtl/mul_writeback_seq.sv | 168 ++++++++++++++++
 tb/tb_mul_writeback_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/risc_spm_pkg.sv
// Shared RISC-SPM definitions: datapath width, opcode set and the MUL
// writeback sequencer state encoding.
package risc_spm_pkg;

  localparam int WORD_SIZE = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_NOT = 4'd4,
    OP_RD  = 4'd5,
    OP_WR  = 4'd6,
    OP_BR  = 4'd7,
    OP_BRZ = 4'd8,
    OP_MUL = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WB_LO = 2'd2,
    S_WB_HI = 2'd3
  } mul_state_e;

  function automatic logic is_wb_state(mul_state_e s);
    return (s == S_WB_LO) || (s == S_WB_HI);
  endfunction

endpackage

// File: rtl/mul_writeback_seq_rise_detect.sv
// Rising-edge detector: registers the level input every cycle and flags a
// 0->1 transition combinationally against the registered copy.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~done_q;

endmodule

// File: rtl/mul_writeback_seq.sv
// MUL writeback sequencer and processor status register for the RISC-SPM.
// Optional macro MUL_ZERO_FLAG_EN: a completed MUL also updates zero_flag.
module mul_writeback_seq
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE   = risc_spm_pkg::WORD_SIZE,
  parameter int REG_ADDR_W  = 2,
  parameter int MUL_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_flags,
  input  logic                  alu_zero_flag,
  input  logic                  alu_overflow_flag,
  input  logic                  mul_start,
  input  logic [REG_ADDR_W-1:0] mul_dest_lsb,
  input  logic [REG_ADDR_W-1:0] mul_dest_msb,
  input  logic                  alu_mul_done_flag,
  input  logic [WORD_SIZE-1:0]  mul_LSB_byte,
  input  logic [WORD_SIZE-1:0]  mul_MSB_byte,
  output logic                  stall,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [WORD_SIZE-1:0]  wb_data,
  output logic                  mul_complete,
  output logic                  mul_err,
  output logic                  zero_flag,
  output logic                  overflow_flag,
  output logic [1:0]            dbg_state
);

  localparam int TMR_W = $clog2(MUL_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MUL_TIMEOUT - 1);

  mul_state_e                  state_q, state_d;
  logic [TMR_W-1:0]            timer_q, timer_d;
  logic [REG_ADDR_W-1:0]       dest_lsb_q, dest_lsb_d;
  logic [REG_ADDR_W-1:0]       dest_msb_q, dest_msb_d;
  logic [2*WORD_SIZE-1:0]      prod_q, prod_d;
  logic                        err_q, err_d;
  logic                        zero_q, zero_d;
  logic                        ovf_q, ovf_d;
  logic                        done_rise;
  logic                        timeout_hit;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (alu_mul_done_flag),
    .rise_o (done_rise)
  );

  // A done edge in the final WAIT cycle takes priority over the abort.
  assign timeout_hit = (state_q == S_WAIT) && !done_rise && (timer_q == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mul_start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise)        state_d = S_WB_LO;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WB_LO: state_d = S_WB_HI;
      S_WB_HI: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d    = timer_q;
    dest_lsb_d = dest_lsb_q;
    dest_msb_d = dest_msb_q;
    prod_d     = prod_q;
    err_d      = 1'b0;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          dest_lsb_d = mul_dest_lsb;
          dest_msb_d = mul_dest_msb;
          timer_d    = '0;
        end
        // The controller is stalled outside IDLE, so only IDLE loads count.
        if (load_flags) begin
          zero_d = alu_zero_flag;
          ovf_d  = alu_overflow_flag;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (done_rise) prod_d = {mul_MSB_byte, mul_LSB_byte};
        err_d = timeout_hit;
      end
      S_WB_HI: begin
        ovf_d = |prod_q[2*WORD_SIZE-1:WORD_SIZE];
`ifdef MUL_ZERO_FLAG_EN
        zero_d = (prod_q == '0);
`else
        zero_d = zero_q;
`endif
      end
      default: begin
        timer_d = timer_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q    <= '0;
      dest_lsb_q <= '0;
      dest_msb_q <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      dest_lsb_q <= dest_lsb_d;
      dest_msb_q <= dest_msb_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
    end
  end

  // Outputs decode only registered state so no input reaches them combinationally.
  always_comb begin
    stall        = (state_q != S_IDLE);
    wb_en        = is_wb_state(state_q);
    wb_addr      = '0;
    wb_data      = '0;
    mul_complete = 1'b0;
    case (state_q)
      S_WB_LO: begin
        wb_addr = dest_lsb_q;
        wb_data = prod_q[WORD_SIZE-1:0];
      end
      S_WB_HI: begin
        wb_addr      = dest_msb_q;
        wb_data      = prod_q[2*WORD_SIZE-1:WORD_SIZE];
        mul_complete = 1'b1;
      end
      default: begin
        wb_addr = '0;
      end
    endcase
  end

  assign mul_err       = err_q;
  assign zero_flag     = zero_q;
  assign overflow_flag = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul_writeback_seq.sv
// Directed bench for mul_writeback_seq: register writes go through an
// expected queue checked by a negedge monitor; status/timing checks inline.
module tb_mul_writeback_seq;

  localparam int W  = 8;
  localparam int AW = 2;
  localparam int EW = 1 + AW + W;  // {mul_complete, wb_addr, wb_data}
`ifdef MUL_ZERO_FLAG_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_flags = 1'b0;
  logic          alu_zero_flag = 1'b0;
  logic          alu_overflow_flag = 1'b0;
  logic          mul_start = 1'b0;
  logic [AW-1:0] mul_dest_lsb = '0;
  logic [AW-1:0] mul_dest_msb = '0;
  logic          alu_mul_done_flag = 1'b0;
  logic [W-1:0]  mul_LSB_byte = '0;
  logic [W-1:0]  mul_MSB_byte = '0;
  logic          stall, wb_en, mul_complete, mul_err, zero_flag, overflow_flag;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int err_pulses = 0;

  mul_writeback_seq dut (
    .clk(clk), .rst_n(rst_n), .load_flags(load_flags),
    .alu_zero_flag(alu_zero_flag), .alu_overflow_flag(alu_overflow_flag),
    .mul_start(mul_start), .mul_dest_lsb(mul_dest_lsb), .mul_dest_msb(mul_dest_msb),
    .alu_mul_done_flag(alu_mul_done_flag), .mul_LSB_byte(mul_LSB_byte),
    .mul_MSB_byte(mul_MSB_byte), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .mul_complete(mul_complete), .mul_err(mul_err),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && wb_en) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", {21'd0, mul_complete, wb_addr, wb_data}, 32'hFFFF_FFFF);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("wb_write", {21'd0, mul_complete, wb_addr, wb_data}, {21'd0, e});
      end
    end
    if (rst_n && mul_err) err_pulses++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_mul(input logic [AW-1:0] dl, input logic [AW-1:0] dm);
    mul_start = 1'b1; mul_dest_lsb = dl; mul_dest_msb = dm;
    tick();
    mul_start = 1'b0; mul_dest_lsb = '0; mul_dest_msb = '0;
  endtask

  task automatic expect_mul(input logic [AW-1:0] dl, input logic [AW-1:0] dm,
                            input logic [W-1:0] lo, input logic [W-1:0] hi);
    exp_q.push_back({1'b0, dl, lo});
    exp_q.push_back({1'b1, dm, hi});
  endtask

  initial begin
    // reset state
    #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("rst_flags", {30'd0, zero_flag, overflow_flag}, 32'd0);
    check("rst_err",   {31'd0, mul_err}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset mid-WAIT with flags set beforehand
    load_flags = 1'b1; alu_zero_flag = 1'b1; alu_overflow_flag = 1'b1;
    tick();
    load_flags = 1'b0;
    start_mul(2'd1, 2'd2);
    tick(); tick();
    check("wait_state", {30'd0, dbg_state}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    check("arst_stall_wb", {30'd0, stall, wb_en}, 32'd0);
    check("arst_flags", {30'd0, zero_flag, overflow_flag}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // load_flags in IDLE: Z=1, O=0
    load_flags = 1'b1; alu_zero_flag = 1'b1; alu_overflow_flag = 1'b0;
    tick();
    load_flags = 1'b0;
    check("flags_load", {30'd0, zero_flag, overflow_flag}, 32'h2);

    // MUL 0x1234, done 5 cycles after start; load_flags during WAIT ignored
    start_mul(2'd1, 2'd2);                      // now cycle 1
    load_flags = 1'b1; alu_zero_flag = 1'b0; alu_overflow_flag = 1'b1;
    tick();                                     // cycle 2
    load_flags = 1'b0;
    check("flags_wait_ignored", {30'd0, zero_flag, overflow_flag}, 32'h2);
    tick(); tick(); tick();                     // cycle 5
    alu_mul_done_flag = 1'b1; mul_LSB_byte = 8'h34; mul_MSB_byte = 8'h12;
    expect_mul(2'd1, 2'd2, 8'h34, 8'h12);
    tick();                                     // cycle 6: WB_LO
    check("wb_lo_stall", {31'd0, stall}, 32'd1);
    tick(); tick();                             // cycle 8: IDLE
    check("mul1_stall_low", {31'd0, stall}, 32'd0);
    check("mul1_ovf", {31'd0, overflow_flag}, 32'd1);
    check("mul1_zero", {31'd0, zero_flag}, ZEN ? 32'd0 : 32'd1);
    alu_mul_done_flag = 1'b0;
    tick();

    // product zero, equal destinations; flags preset Z=0, O=1
    load_flags = 1'b1; alu_zero_flag = 1'b0; alu_overflow_flag = 1'b1;
    tick();
    load_flags = 1'b0;
    start_mul(2'd3, 2'd3);
    tick();
    alu_mul_done_flag = 1'b1; mul_LSB_byte = 8'h00; mul_MSB_byte = 8'h00;
    expect_mul(2'd3, 2'd3, 8'h00, 8'h00);
    tick(); tick(); tick();
    check("mul0_ovf", {31'd0, overflow_flag}, 32'd0);
    check("mul0_zero", {31'd0, zero_flag}, ZEN ? 32'd1 : 32'd0);
    alu_mul_done_flag = 1'b0;
    tick();

    // timeout: no done for 32 WAIT cycles
    start_mul(2'd1, 2'd0);                      // cycle 1, timer 0
    for (int i = 0; i < 31; i++) tick();        // cycle 32, timer 31
    check("to_last_wait", {29'd0, stall, dbg_state}, 32'h5);
    check("to_no_err_yet", {31'd0, mul_err}, 32'd0);
    tick();                                     // cycle 33
    check("to_err_pulse", {30'd0, mul_err, stall}, 32'h2);
    tick();
    check("to_err_once", {31'd0, mul_err}, 32'd0);

    // done edge exactly on the timeout cycle wins
    start_mul(2'd2, 2'd0);
    for (int i = 0; i < 31; i++) tick();        // cycle 32
    alu_mul_done_flag = 1'b1; mul_LSB_byte = 8'hCD; mul_MSB_byte = 8'hAB;
    expect_mul(2'd2, 2'd0, 8'hCD, 8'hAB);
    tick();
    check("race_wb_lo", {29'd0, mul_err, dbg_state}, 32'h2);
    tick(); tick();
    check("race_ovf", {31'd0, overflow_flag}, 32'd1);
    alu_mul_done_flag = 1'b0;
    tick();

    // mul_start during WB_LO is ignored; next op needs a fresh done edge
    start_mul(2'd1, 2'd3);                      // cycle 1
    tick();                                     // cycle 2
    alu_mul_done_flag = 1'b1; mul_LSB_byte = 8'h77; mul_MSB_byte = 8'h00;
    expect_mul(2'd1, 2'd3, 8'h77, 8'h00);
    tick();                                     // cycle 3: WB_LO
    mul_start = 1'b1; mul_dest_lsb = 2'd0; mul_dest_msb = 2'd0;
    tick();                                     // cycle 4: WB_HI
    mul_start = 1'b0;
    tick();                                     // cycle 5: IDLE
    check("ignored_start", {29'd0, stall, dbg_state}, 32'd0);
    start_mul(2'd2, 2'd1);                      // done still high
    for (int i = 0; i < 5; i++) tick();
    check("no_edge_still_wait", {29'd0, stall, dbg_state}, 32'h5);
    alu_mul_done_flag = 1'b0;
    tick();
    alu_mul_done_flag = 1'b1; mul_LSB_byte = 8'h5A; mul_MSB_byte = 8'hA5;
    expect_mul(2'd2, 2'd1, 8'h5A, 8'hA5);
    tick(); tick(); tick();
    check("fresh_edge_done", {31'd0, stall}, 32'd0);
    alu_mul_done_flag = 1'b0;
    tick(); tick();

    // final report
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("err_pulse_count", err_pulses, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
